jk_counter: RTL and testbench

//  Parametrised WIDTH-bit register bank built from per-bit JK cells. It runs as
//  a raw JK bank or as a synchronous up/down/loadable counter.

---
 rtl/jk_pkg.sv | 23 ++
 rtl/jk_cell.sv | 22 ++
 rtl/jk_counter.sv | 114 +++++++++++
 tb/tb_jk_counter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and the JK cell truth table for the jk_counter register bank.
package jk_pkg;

   typedef enum logic [1:0] {
      MODE_JK   = 2'b00,
      MODE_UP   = 2'b01,
      MODE_DOWN = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   // Classic JK next state: hold, reset, set, toggle.
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic nq;
      case ({j, k})
         2'b00:   nq = q;
         2'b01:   nq = 1'b0;
         2'b10:   nq = 1'b1;
         default: nq = ~q;
      endcase
      return nq;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage bit with synchronous reset to a per-bit reset value and a
// cycle enable.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic j,
   input  logic k,
   input  logic rst_val,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst)
         q <= rst_val;
      else if (en)
         q <= jk_next(q, j, k);
   end

endmodule

// File: rtl/jk_counter.sv
// WIDTH-bit bank of JK cells usable as a raw JK register or an up/down/load
// counter. Define JKC_SAT_EN to saturate at the count boundaries instead of wrapping.
module jk_counter
   import jk_pkg::*;
#(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  mode_t            mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic [WIDTH-1:0] cell_j;
   logic [WIDTH-1:0] cell_k;
   logic [WIDTH-1:0] low_mask;
   logic             at_max;
   logic             at_zero;
   logic             wrap_next;

   assign at_max  = &q;
   assign at_zero = ~|q;

   // Bit i toggles when every lower bit is 1 (up) or 0 (down); masking the
   // upper bits keeps the chain free of combinational self-reference.
   always_comb begin
      t_up     = '0;
      t_dn     = '0;
      low_mask = '0;
      for (int i = 0; i < WIDTH; i++) begin
         low_mask = (WIDTH'(1) << i) - WIDTH'(1);
         t_up[i]  = &(q | ~low_mask);
         t_dn[i]  = &(~q | ~low_mask);
      end
   end

   always_comb begin
      cell_j = '0;
      cell_k = '0;
      case (mode)
         MODE_JK: begin
            cell_j = j;
            cell_k = k;
         end
         MODE_UP: begin
`ifdef JKC_SAT_EN
            if (!at_max) begin
               cell_j = t_up;
               cell_k = t_up;
            end
`else
            cell_j = t_up;
            cell_k = t_up;
`endif
         end
         MODE_DOWN: begin
`ifdef JKC_SAT_EN
            if (!at_zero) begin
               cell_j = t_dn;
               cell_k = t_dn;
            end
`else
            cell_j = t_dn;
            cell_k = t_dn;
`endif
         end
         default: begin
            cell_j = d;
            cell_k = ~d;
         end
      endcase
   end

   assign tc = ((mode == MODE_UP) && at_max) || ((mode == MODE_DOWN) && at_zero);

`ifdef JKC_SAT_EN
   assign wrap_next = 1'b0;
`else
   // A wrap happens exactly when an enabled count step leaves a terminal value.
   assign wrap_next = en && tc;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_cell
         jk_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .j       (cell_j[gi]),
            .k       (cell_k[gi]),
            .rst_val (RST_VAL[gi]),
            .q       (q[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         wrap <= 1'b0;
      else
         wrap <= wrap_next;
   end

endmodule

// File: tb/tb_jk_counter.sv
// Scoreboard bench for jk_counter (WIDTH=4, RST_VAL=0); covers the saturating
// variant when JKC_SAT_EN is defined.
module tb_jk_counter;
   import jk_pkg::*;

   typedef struct {
      string      name;
      logic [3:0] q;
      logic       tc;
      logic       wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   mode_t      mode;
   logic [3:0] j;
   logic [3:0] k;
   logic [3:0] d;
   logic [3:0] q;
   logic       tc;
   logic       wrap;

   exp_t sb[$];
   int   tests_run = 0;
   int   failures  = 0;

   jk_counter #(.WIDTH(4), .RST_VAL(4'h0)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .j    (j),
      .k    (k),
      .d    (d),
      .q    (q),
      .tc   (tc),
      .wrap (wrap)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, queue the expected post-edge outputs, and hold
   // the inputs until just after the following falling edge.
   task automatic applyStimulus(input string name, input logic r, input logic e,
                                input mode_t m, input logic [3:0] jv, input logic [3:0] kv,
                                input logic [3:0] dv, input logic [3:0] eq,
                                input logic etc, input logic ewrap);
      exp_t x;
      rst  = r;
      en   = e;
      mode = m;
      j    = jv;
      k    = kv;
      d    = dv;
      x.name = name;
      x.q    = eq;
      x.tc   = etc;
      x.wrap = ewrap;
      sb.push_back(x);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic checkOutput(input exp_t x);
      tests_run += 3;
      if (q !== x.q) begin
         failures++;
         $display("[TB] FAIL %s q: got %h expected %h", x.name, q, x.q);
      end
      if (tc !== x.tc) begin
         failures++;
         $display("[TB] FAIL %s tc: got %b expected %b", x.name, tc, x.tc);
      end
      if (wrap !== x.wrap) begin
         failures++;
         $display("[TB] FAIL %s wrap: got %b expected %b", x.name, wrap, x.wrap);
      end
   endtask

   // Monitor: every falling edge after an issued cycle presents a result.
   always @(negedge clk) begin
      if (sb.size() > 0) checkOutput(sb.pop_front());
   end

   initial begin
      rst = 1'b1; en = 1'b0; mode = MODE_JK; j = '0; k = '0; d = '0;
      @(negedge clk);
      #1;

      applyStimulus("reset0", 1, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
      applyStimulus("reset1", 1, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

      applyStimulus("jk_set",    0, 1, MODE_JK, 4'hA, 4'h0, 4'h0, 4'hA, 0, 0);
      applyStimulus("jk_clr",    0, 1, MODE_JK, 4'h0, 4'h2, 4'h0, 4'h8, 0, 0);
      applyStimulus("jk_toggle", 0, 1, MODE_JK, 4'hF, 4'hF, 4'h0, 4'h7, 0, 0);
      applyStimulus("jk_hold",   0, 1, MODE_JK, 4'h0, 4'h0, 4'hF, 4'h7, 0, 0);

      applyStimulus("load5",    0, 1, MODE_LOAD, 4'hF, 4'hF, 4'h5, 4'h5, 0, 0);
      for (int i = 0; i < 3; i++)
         applyStimulus("en0_hold", 0, 0, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h5, 0, 0);
      applyStimulus("up6",      0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h6, 0, 0);
      applyStimulus("up7",      0, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h7, 0, 0);
      applyStimulus("rst_mid",  1, 1, MODE_UP, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

`ifdef JKC_SAT_EN
      applyStimulus("sat_load14", 0, 1, MODE_LOAD, 4'h0, 4'h0, 4'hE, 4'hE, 0, 0);
      applyStimulus("sat_up15",   0, 1, MODE_UP,   4'h0, 4'h0, 4'h0, 4'hF, 1, 0);
      applyStimulus("sat_up_hold", 0, 1, MODE_UP,  4'h0, 4'h0, 4'h0, 4'hF, 1, 0);
      applyStimulus("sat_up_hold", 0, 1, MODE_UP,  4'h0, 4'h0, 4'h0, 4'hF, 1, 0);
      applyStimulus("sat_load0",  0, 1, MODE_LOAD, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
      applyStimulus("sat_dn_hold", 0, 1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
      applyStimulus("sat_dn_hold", 0, 1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
`else
      for (int i = 1; i <= 16; i++)
         applyStimulus("up_count", 0, 1, MODE_UP, 4'h0, 4'h0, 4'h0,
                       4'(i % 16), (i == 15), (i == 16));

      applyStimulus("load3", 0, 1, MODE_LOAD, 4'h0, 4'h0, 4'h3, 4'h3, 0, 0);
      applyStimulus("dn2",   0, 1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 4'h2, 0, 0);
      applyStimulus("dn1",   0, 1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 4'h1, 0, 0);
      applyStimulus("dn0",   0, 1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 4'h0, 1, 0);
      applyStimulus("dn15",  0, 1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 4'hF, 0, 1);

      applyStimulus("loadF",     0, 1, MODE_LOAD, 4'h0, 4'h0, 4'hF, 4'hF, 0, 0);
      applyStimulus("en0_at_max", 0, 0, MODE_UP,  4'h0, 4'h0, 4'h0, 4'hF, 1, 0);
      applyStimulus("wrap_up",   0, 1, MODE_UP,   4'h0, 4'h0, 4'h0, 4'h0, 0, 1);
      applyStimulus("wrap_drop", 0, 0, MODE_UP,   4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
      applyStimulus("jk_after_up", 0, 1, MODE_JK, 4'h5, 4'h0, 4'h0, 4'h5, 0, 0);
`endif

      for (int c = 0; c < 5 && sb.size() > 0; c++) @(negedge clk);
      if (sb.size() > 0) begin
         failures++;
         $display("[TB] FAIL drain: got %0d pending results expected 0", sb.size());
      end
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
